// File: rtl/ring_sequencer_if.sv
// rtl/ring_sequencer_if.sv - control and status bundle of the ring/Johnson phase sequencer
interface ring_sequencer_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2 * WIDTH);

    logic             enable;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic [PW-1:0]    phase;
    logic             wrap;
    logic             illegal;

    modport master (
        output enable, dir, load, load_val,
        input  Q, phase, wrap, illegal
    );

    modport slave (
        input  enable, dir, load, load_val,
        output Q, phase, wrap, illegal
    );
endinterface

// File: rtl/ring_sequencer.sv
// rtl/ring_sequencer.sv - one-hot / one-cold / Johnson phase sequencer with load, hold and self-correction
module ring_sequencer #(
    parameter int WIDTH     = 4,
    parameter int MODE      = 1,
    parameter int RESET_POS = 0
) (
    input  logic               clock,
    input  logic               reset,
    ring_sequencer_if.slave    s
);
    localparam int PW = $clog2(2 * WIDTH);
    localparam int N  = (MODE == 2) ? 2 * WIDTH : WIDTH;
    localparam logic [WIDTH-1:0] HOT0   = WIDTH'(1) << RESET_POS;
    localparam logic [WIDTH-1:0] PHASE0 = (MODE == 2) ? '0 : ((MODE == 1) ? ~HOT0 : HOT0);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_act;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_rev;
    logic [PW-1:0]    w_phase;
    logic             w_illegal;
    int               w_cnt;
    int               w_idx;
    int               w_trans;
    int               w_ph;

    // In one-cold mode the active bit is the zero, so count on the inverted pattern.
    assign w_act = (MODE == 1) ? ~r_q : r_q;

    always_comb begin
        w_cnt     = 0;
        w_idx     = 0;
        w_trans   = 0;
        w_ph      = 0;
        w_illegal = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_act[i]) begin
                w_cnt = w_cnt + 1;
                w_idx = i;
            end
        end
        // A legal Johnson word is a single run boundary: 1..10..0 or 0..01..1.
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (r_q[i] != r_q[i+1]) w_trans = w_trans + 1;
        end
        if (MODE == 2) begin
            w_illegal = (w_trans > 1);
            if (w_illegal)             w_ph = 0;
            else if (r_q[WIDTH-1])     w_ph = w_cnt;
            else if (w_cnt == 0)       w_ph = 0;
            else                       w_ph = 2 * WIDTH - w_cnt;
        end else begin
            w_illegal = (w_cnt != 1);
            if (w_illegal)                w_ph = 0;
            else if (w_idx <= RESET_POS)  w_ph = RESET_POS - w_idx;
            else                          w_ph = RESET_POS + WIDTH - w_idx;
        end
    end

    assign w_phase = PW'(w_ph);
    assign w_fwd   = {(MODE == 2) ? ~r_q[0] : r_q[0], r_q[WIDTH-1:1]};
    assign w_rev   = {r_q[WIDTH-2:0], (MODE == 2) ? ~r_q[WIDTH-1] : r_q[WIDTH-1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= PHASE0;
        end else if (s.load) begin
            r_q <= s.load_val;
        end else if (w_illegal) begin
            r_q <= PHASE0;
        end else if (s.enable) begin
            r_q <= s.dir ? w_rev : w_fwd;
        end
    end

    assign s.Q       = r_q;
    assign s.phase   = w_phase;
    assign s.illegal = w_illegal;
    assign s.wrap    = s.enable & ~s.load & ~w_illegal &
                       ((~s.dir & (w_phase == PW'(N - 1))) | (s.dir & (w_phase == '0)));
endmodule

// File: tb/tb_ring_sequencer.sv
// tb/tb_ring_sequencer.sv - randomized and directed check of three ring_sequencer configurations
module tb_ring_sequencer;
    localparam int NDUT = 3;
    localparam int MODES[NDUT] = '{1, 2, 0};
    localparam int RPOS [NDUT] = '{0, 0, 2};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, dr = 1'b0, ld = 1'b0;
    logic [3:0] lv = 4'd0;

    always #5 clock = ~clock;

    ring_sequencer_if #(.WIDTH(4)) if_a ();
    ring_sequencer_if #(.WIDTH(4)) if_b ();
    ring_sequencer_if #(.WIDTH(4)) if_c ();

    assign if_a.enable = en;  assign if_a.dir = dr;  assign if_a.load = ld;  assign if_a.load_val = lv;
    assign if_b.enable = en;  assign if_b.dir = dr;  assign if_b.load = ld;  assign if_b.load_val = lv;
    assign if_c.enable = en;  assign if_c.dir = dr;  assign if_c.load = ld;  assign if_c.load_val = lv;

    ring_sequencer #(.WIDTH(4), .MODE(1), .RESET_POS(0)) u_a (.clock(clock), .reset(reset), .s(if_a.slave));
    ring_sequencer #(.WIDTH(4), .MODE(2), .RESET_POS(0)) u_b (.clock(clock), .reset(reset), .s(if_b.slave));
    ring_sequencer #(.WIDTH(4), .MODE(0), .RESET_POS(2)) u_c (.clock(clock), .reset(reset), .s(if_c.slave));

    logic [3:0] d_q  [NDUT];
    logic [2:0] d_ph [NDUT];
    logic       d_wr [NDUT];
    logic       d_il [NDUT];
    assign d_q[0] = if_a.Q;  assign d_ph[0] = if_a.phase;  assign d_wr[0] = if_a.wrap;  assign d_il[0] = if_a.illegal;
    assign d_q[1] = if_b.Q;  assign d_ph[1] = if_b.phase;  assign d_wr[1] = if_b.wrap;  assign d_il[1] = if_b.illegal;
    assign d_q[2] = if_c.Q;  assign d_ph[2] = if_c.phase;  assign d_wr[2] = if_c.wrap;  assign d_il[2] = if_c.illegal;

    logic [3:0] m_q [NDUT];
    int vec = 0;
    int err = 0;

    function automatic int nstates(int mode);
        return (mode == 2) ? 8 : 4;
    endfunction

    // Pattern that represents phase p, built directly from the phase definition.
    function automatic logic [3:0] pat(int mode, int rp, int p);
        logic [3:0] q;
        q = '0;
        if (mode == 2) begin
            for (int i = 0; i < 4; i++)
                q[i] = (p <= 4) ? (i >= 4 - p) : (i < 8 - p);
        end else begin
            q[(rp - p + 8) % 4] = 1'b1;
            if (mode == 1) q = ~q;
        end
        return q;
    endfunction

    // Phase of q by search over all legal patterns; -1 when q is not one of them.
    function automatic int find_phase(int mode, int rp, logic [3:0] q);
        for (int p = 0; p < nstates(mode); p++)
            if (pat(mode, rp, p) == q) return p;
        return -1;
    endfunction

    task automatic chk(string name, int k, logic [15:0] act, logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            int  ph, n;
            logic il, wr;
            n  = nstates(MODES[k]);
            ph = find_phase(MODES[k], RPOS[k], m_q[k]);
            il = (ph < 0);
            if (il) ph = 0;
            wr = en & ~ld & ~il & ((~dr & (ph == n - 1)) | (dr & (ph == 0)));
            chk("Q",       k, 16'(d_q[k]),  16'(m_q[k]));
            chk("phase",   k, 16'(d_ph[k]), 16'(ph));
            chk("illegal", k, 16'(d_il[k]), 16'(il));
            chk("wrap",    k, 16'(d_wr[k]), 16'(wr));
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            int ph, n;
            n  = nstates(MODES[k]);
            ph = find_phase(MODES[k], RPOS[k], m_q[k]);
            if (!reset)      m_q[k] = pat(MODES[k], RPOS[k], 0);
            else if (ld)     m_q[k] = lv;
            else if (ph < 0) m_q[k] = pat(MODES[k], RPOS[k], 0);
            else if (en)     m_q[k] = pat(MODES[k], RPOS[k], (ph + (dr ? n - 1 : 1)) % n);
        end
    endtask

    task automatic set_reset(logic v);
        reset = v;
        if (!v)
            for (int k = 0; k < NDUT; k++) m_q[k] = pat(MODES[k], RPOS[k], 0);
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        logic [3:0] a_q  [6];
        logic [2:0] a_ph [6];
        logic [3:0] b_q  [9];
        a_q  = '{4'b1110, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};
        a_ph = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        b_q  = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

        #2 set_reset(1'b0);
        step();
        chk("rst_a_q",  0, 16'(if_a.Q), 16'h000e);
        chk("rst_b_q",  1, 16'(if_b.Q), 16'h0000);
        chk("rst_c_q",  2, 16'(if_c.Q), 16'h0004);
        chk("rst_a_ph", 0, 16'(if_a.phase), 16'd0);
        chk("rst_a_il", 0, 16'(if_a.illegal), 16'd0);
        chk("rst_a_wr", 0, 16'(if_a.wrap), 16'd0);
        set_reset(1'b1);
        step();

        en = 1'b1; dr = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            #1;
            if (i <= 5) begin
                chk("fwd_a_q",  0, 16'(if_a.Q),     16'(a_q[i]));
                chk("fwd_a_ph", 0, 16'(if_a.phase), 16'(a_ph[i]));
                chk("fwd_a_wr", 0, 16'(if_a.wrap),  16'(a_ph[i] == 3'd3));
            end
            chk("fwd_b_q",  1, 16'(if_b.Q),     16'(b_q[i]));
            chk("fwd_b_ph", 1, 16'(if_b.phase), 16'(i % 8));
            if (i < 8) step();
        end
        dr = 1'b1;
        step();
        chk("rev_b_q",  1, 16'(if_b.Q),     16'h0001);
        chk("rev_b_ph", 1, 16'(if_b.phase), 16'd7);

        set_reset(1'b0);
        #1 chk("rst_c_q2", 2, 16'(if_c.Q), 16'h0004);
        step();
        set_reset(1'b1);
        en = 1'b1; dr = 1'b1;
        #1 chk("rev_c_wr", 2, 16'(if_c.wrap), 16'd1);
        step();
        chk("rev_c_q",  2, 16'(if_c.Q),     16'h0008);
        chk("rev_c_ph", 2, 16'(if_c.phase), 16'd3);

        dr = 1'b0; en = 1'b1; ld = 1'b1; lv = 4'b1011;
        step();
        chk("ld_a_q",  0, 16'(if_a.Q),     16'h000b);
        chk("ld_a_ph", 0, 16'(if_a.phase), 16'd2);
        lv = 4'b1001;
        step();
        chk("ill_a_il", 0, 16'(if_a.illegal), 16'd1);
        chk("ill_a_ph", 0, 16'(if_a.phase),   16'd0);
        ld = 1'b0; en = 1'b0;
        step();
        chk("fix_a_q",  0, 16'(if_a.Q),       16'h000e);
        chk("fix_a_il", 0, 16'(if_a.illegal), 16'd0);

        en = 1'b1;
        repeat (3) step();
        chk("pre_hold", 0, 16'(if_a.Q), 16'h000d);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_a_q", 0, 16'(if_a.Q), 16'h000d);
        end
        set_reset(1'b0);
        ld = 1'b1; lv = 4'b1011;
        #1 chk("async_a_q", 0, 16'(if_a.Q), 16'h000e);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_ld_a_q", 0, 16'(if_a.Q), 16'h000e);
        end
        ld = 1'b0;
        set_reset(1'b1);

        repeat (800) begin
            en = ($urandom_range(0, 3) != 0);
            dr = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 7) == 0);
            lv = 4'($urandom);
            if ($urandom_range(0, 63) == 0) set_reset(1'b0);
            else                            set_reset(1'b1);
            step();
        end
        set_reset(1'b1);
        en = 1'b0; ld = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/ring_sequencer.md
# ring_sequencer

Parametrised ring/Johnson phase sequencer for the single-cycle processor's control timing. It generalises the fixed 4-bit one-cold ring counter in three ways: it has configurable width and encoding mode, it can step in either direction, and it supports load, hold and self-correction. It also outputs a binary phase index and a wrap pulse, so downstream control logic can decode the current step without re-deriving it from the one-hot or one-cold pattern.

## Interface
- WIDTH, 4: number of state bits Q; legal range 2..16.
- MODE, 1: encoding; 0 = one-hot ring, 1 = one-cold ring, 2 = Johnson (twisted ring).
- RESET_POS, 0: bit index of the active bit at phase 0 (ring modes only; ignored in Johnson).
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  advance one step on this edge.
- dir  input  1  0 = forward (phase +1), 1 = reverse (phase −1).
- load  input  1  synchronous raw load of load_val.
- load_val  input  WIDTH  pattern written to Q on load.
- Q  output  WIDTH  registered state pattern.
- phase  output  PW  binary phase index, where PW = $clog2(2*WIDTH); combinational from Q.
- wrap  output  1  combinational; high when the next edge steps onto phase 0 (forward) or onto N−1 (reverse).
- illegal  output  1  combinational; Q is not a legal pattern for MODE.

## Operation
- N (states) = WIDTH in ring modes and 2*WIDTH in Johnson mode.
- Phase 0 patterns:
  - one-hot: only bit RESET_POS = 1.
  - one-cold: only bit RESET_POS = 0 (WIDTH=4, RESET_POS=0 gives 4'b1110).
  - Johnson: all zeros.
- Forward step:
  - Ring: Q <= {Q[0], Q[WIDTH-1:1]}, i.e. rotate right; the active bit moves from bit i to bit i−1 mod WIDTH.
  - Johnson: Q <= {~Q[0], Q[WIDTH-1:1]}.
- Reverse step:
  - Ring: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - Johnson: Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]}.
- phase:
  - Ring: (RESET_POS − active_index) mod WIDTH.
  - Johnson: if Q[WIDTH-1] = 1, phase = count of ones; otherwise phase = 2*WIDTH − count of ones, and 0 when Q is all zeros.
  - phase = 0 whenever illegal = 1.
- illegal:
  - Ring: the number of active bits ≠ 1.
  - Johnson: Q is not of the form 1…10…0 or 0…01…1.
- Edge priority, highest first:
  1. reset low: Q = phase-0 pattern, asynchronously.
  2. load: Q <= load_val, with no legality check; enable and dir are ignored.
  3. illegal (and load = 0): Q <= phase-0 pattern, regardless of enable.
  4. enable: step in the direction given by dir.
  5. Otherwise: hold.
- wrap = enable & ~load & ~illegal & ((~dir & phase == N−1) | (dir & phase == 0)).

## Timing
- Reset values:
  - Q = phase-0 pattern.
  - phase = 0.
  - illegal = 0.
  - wrap = 0 while enable is low.
- Deassertion of reset is taken synchronously on the next rising edge; the first step can occur on the first edge after reset is high.
- Step latency: one clock. Q, phase and illegal update in the same cycle, after the edge.
- Loading an illegal pattern:
  - illegal is high for exactly one cycle.
  - The following edge restores phase 0, unless load is still asserted.
- dir may change on any cycle, including on the wrap cycle; the next state is computed from the current value only.
- Reset asserted mid-operation overrides load and enable immediately; no edge is needed.

## Test plan
- Default parameters (WIDTH=4, MODE=1):
  - Stimulus: release reset, enable=1, dir=0 for 5 edges.
  - Required response: Q = 1110, 0111, 1011, 1101, 1110, 0111; phase = 0, 1, 2, 3, 0, 1; wrap high only while phase = 3.
- MODE=2, WIDTH=4:
  - Stimulus: forward 8 edges.
  - Required response: Q = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; phase = 0..7, 0.
  - Stimulus: then reverse 1 edge.
  - Required response: Q = 0001, phase = 7.
- MODE=0, WIDTH=4, RESET_POS=2:
  - Stimulus: reset.
  - Required response: Q = 0100.
  - Stimulus: reverse 1 edge.
  - Required response: Q = 1000, phase = 3, and wrap was high before the edge.
- Load legal/illegal, MODE=1:
  - Stimulus: load_val = 1011 with enable=1.
  - Required response: Q = 1011, phase = 2; enable has no effect on the load edge.
  - Stimulus: load_val = 1001.
  - Required response: illegal = 1 and phase = 0 for one cycle; next edge gives Q = 1110 even with enable=0.
- Hold and async reset:
  - Stimulus: enable=0 for 3 edges.
  - Required response: Q unchanged.
  - Stimulus: pull reset low between edges while Q = 1101.
  - Required response: Q = 1110 within the same cycle.
  - Stimulus: keep load=1 during reset.
  - Required response: Q stays 1110.
